// File: rtl/corg_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// corg_pkg : shared widths and the write-back entry type for the CORG core
// rev 1.0
// ----------------------------------------------------------------------------
package corg_pkg;

  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 3;
  localparam int NUM_REGS = 1 << ADDR_W;

  typedef struct packed {
    logic [ADDR_W-1:0] dest;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage
`default_nettype wire

// File: rtl/wb_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// wb_fifo : count-based synchronous FIFO holding pending load results
// rev 1.0
// ----------------------------------------------------------------------------
module wb_fifo #(
  parameter int WIDTH = 19,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    if (push_i && !pop_i)      count_d = count_q + CNT_W'(1);
    else if (!push_i && pop_i) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_i) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/writeback_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// writeback_unit : ALU/load write-port arbiter with load-pending scoreboard
// rev 1.0
// ----------------------------------------------------------------------------
module writeback_unit #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 3,
  parameter int LQ_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 alu_valid,
  input  logic [ADDR_W-1:0]    alu_dest,
  input  logic [DATA_W-1:0]    alu_data,
  input  logic                 load_issue_valid,
  input  logic [ADDR_W-1:0]    load_issue_dest,
  input  logic                 mem_valid,
  output logic                 mem_ready,
  input  logic [ADDR_W-1:0]    mem_dest,
  input  logic [DATA_W-1:0]    mem_data,
  output logic                 write_enable,
  output logic [ADDR_W-1:0]    write_destination,
  output logic [DATA_W-1:0]    write_data,
  output logic [2**ADDR_W-1:0] pending
);

  localparam int NREGS   = 1 << ADDR_W;
  localparam int ENTRY_W = ADDR_W + DATA_W;

  logic [ENTRY_W-1:0] head;
  logic               fifo_full, fifo_empty;
  logic               push, pop;
  logic [ADDR_W-1:0]  head_dest;
  logic [DATA_W-1:0]  head_data;

  logic               we_q;
  logic [ADDR_W-1:0]  wa_q;
  logic [DATA_W-1:0]  wd_q;
  logic [NREGS-1:0]   pending_q, pending_d;

  assign mem_ready = !fifo_full;
  assign push      = mem_valid && !fifo_full;
  // ALU has fixed priority; the buffer only drains on ALU-idle cycles
  assign pop       = !alu_valid && !fifo_empty;
  assign head_dest = head[ENTRY_W-1 -: ADDR_W];
  assign head_data = head[DATA_W-1:0];

  wb_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (LQ_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .push_data_i ({mem_dest, mem_data}),
    .pop_i       (pop),
    .head_o      (head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  // Set is applied after clear so a same-edge re-issue keeps the bit high
  always_comb begin
    pending_d = pending_q;
    if (pop)              pending_d[head_dest]       = 1'b0;
    if (load_issue_valid) pending_d[load_issue_dest] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      we_q      <= 1'b0;
      wa_q      <= '0;
      wd_q      <= '0;
      pending_q <= '0;
    end else begin
      we_q      <= alu_valid || pop;
      pending_q <= pending_d;
      if (alu_valid) begin
        wa_q <= alu_dest;
        wd_q <= alu_data;
      end else if (pop) begin
        wa_q <= head_dest;
        wd_q <= head_data;
      end
    end
  end

  assign write_enable      = we_q;
  assign write_destination = wa_q;
  assign write_data        = wd_q;
  assign pending           = pending_q;

endmodule
`default_nettype wire

// File: doc/writeback_unit.md
# writeback_unit

Write-back stage of the CORG processor; the sole driver of the register file's write port (`write_enable`, `write_destination`, `write_data`). It merges single-cycle ALU results with variable-latency memory load responses, buffers up to two load results, and keeps a per-register pending scoreboard that issue logic uses to stall reads and writes of registers with outstanding loads.

## Interface
Parameters:
- `DATA_W`, 16, register data width
- `ADDR_W`, 3, register address width (8 registers)
- `LQ_DEPTH`, 2, load-result buffer entries (power of two)

Ports:
- `clk`  in  1  system clock, all state on rising edge
- `rst`  in  1  reset, synchronous, active-low (asserted when 0)
- `alu_valid`  in  1  ALU result present this cycle; never stalled
- `alu_dest`  in  ADDR_W  ALU destination register
- `alu_data`  in  DATA_W  ALU result
- `load_issue_valid`  in  1  a load to `load_issue_dest` issued this cycle
- `load_issue_dest`  in  ADDR_W  destination of issued load
- `mem_valid`  in  1  load response valid
- `mem_ready`  out  1  buffer can accept a response (= not full)
- `mem_dest`  in  ADDR_W  load destination register
- `mem_data`  in  DATA_W  load data
- `write_enable`  out  1  register file write strobe
- `write_destination`  out  ADDR_W  register file write address
- `write_data`  out  DATA_W  register file write data
- `pending`  out  2**ADDR_W  bit i = load outstanding to register i

## Operation
- Reset (`rst`=0 at an edge): `write_enable`=0, `write_destination`=0, `write_data`=0, `pending`=0, buffer emptied, `mem_ready`=1 in the following cycle. Reset mid-operation discards buffered results and pending bits; no write is emitted.
- Load accept: a response is taken when `mem_valid && mem_ready`; pushed into the FIFO tail. `mem_ready` = !full, combinational from the count only (not from `mem_valid`).
- Arbitration each cycle: ALU has fixed priority. If `alu_valid`, the write port register loads the ALU result. Otherwise, if the FIFO is non-empty, the head is popped and loaded. Otherwise `write_enable`=0 next cycle and address/data hold their previous values.
- Push and pop in the same cycle are legal when full: the pop frees the entry, but `mem_ready` was already 0, so no push occurs. When empty, a push and "pop" in the same cycle cannot happen (no bypass).
- Scoreboard: `load_issue_valid` sets `pending[load_issue_dest]`. A load write-back (pop) clears `pending[head.dest]` on the same edge that loads the write port. Set and clear of the same bit on the same edge: set wins. ALU writes never touch `pending`.
- Issue logic guarantees no ALU write targets a pending register (WAW). The unit does not check this.
- Continuous `alu_valid` starves the FIFO. The FIFO fills, `mem_ready` drops, and the memory side stalls. This is required behaviour, not an error.

## Timing
- ALU path latency 1: result at cycle N appears on the write port in cycle N+1 with `write_enable`=1 for exactly one cycle per result.
- Load path minimum latency 2: accepted at N, head visible at N+1, driven on the write port in N+2 if `alu_valid`=0 at N+1.
- `pending` is registered: a set is visible the cycle after issue. A clear is visible in the same cycle as the corresponding `write_enable`.
- Write order for loads is FIFO (acceptance order). Back-to-back writes are sustained at one per cycle.

## Structure
- Shared package `corg_pkg`: `DATA_W`, `ADDR_W`, `NUM_REGS`, typedef `wb_entry_t` {dest, data}.
- One sub-module, `wb_fifo`: a LQ_DEPTH-entry synchronous FIFO with a count-based full/empty, push/pop, and a head output. Arbitration, write-port registers and scoreboard live in `writeback_unit`.

## Test plan
- Reset: hold `rst`=0 for 2 cycles with random inputs → all outputs 0 and `mem_ready`=1 after release.
- ALU only: `alu_valid`, dest 1, data 16'h09A5 at N → cycle N+1 has `write_enable`=1, dest 1, data 16'h09A5; cycle N+2 has `write_enable`=0.
- Load with scoreboard: issue dest 2, then a response 3 cycles later with data 16'hA357 and no ALU → `pending[2]`=1 from the cycle after issue. The write of dest 2 / 16'hA357 occurs 2 cycles after the response, with `pending[2]`=0 in that same cycle.
- Priority and backpressure: `alu_valid` held high 6 cycles while 3 responses arrive → the first two are accepted, then `mem_ready`=0. ALU writes occur every cycle; the loads then drain in order on the cycles after ALU stops, with `mem_ready`=1 after the first pop.
- Same-edge set/clear: the head load to dest 4 pops on the same edge as a new issue to dest 4 → `pending[4]` stays 1.
- Reset mid-drain: FIFO full with pending bits set, assert `rst` → no further `write_enable`, and `pending`=0.
